// File: rtl/rv_pkg.sv
// Shared RV32 definitions: base opcodes, the canonical NOP and fetch FSM states.
package rv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request, an instruction register
// feeding the decoder, and redirect handling with stale-response killing.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            incr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            fetch_misalign
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic         kill;

    assign imem_addr = pc;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            FETCH: begin
                imem_req   = !reset;
                state_next = WAIT;
            end
            WAIT: begin
                if (imem_rvalid)
                    state_next = (redirect_valid || kill) ? FETCH : HOLD;
            end
            HOLD: begin
                if (redirect_valid || !stall)
                    state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            kill           <= 1'b0;
            instr_valid    <= 1'b0;
            instr          <= NOP_INSTR;
            fetch_misalign <= 1'b0;
        end else begin
            state          <= state_next;
            fetch_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                // A request in flight (issued now, or still unanswered) belongs to the old path.
                pc          <= {redirect_pc[XLEN-1:2], 2'b00};
                instr_valid <= 1'b0;
                kill        <= (state == FETCH) || ((state == WAIT) && !imem_rvalid);
            end else begin
                case (state)
                    WAIT: begin
                        if (imem_rvalid) begin
                            if (kill) begin
                                kill <= 1'b0;
                            end else begin
                                instr       <= imem_rdata;
                                instr_valid <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            pc          <= incr ? pc + XLEN'(4) : pc;
                            instr_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected requests and
// presented instructions; a negedge monitor pops and compares them.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_instr_t;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        incr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fetch_misalign;

    logic        mem_auto;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        man_rvalid;
    logic [31:0] man_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_req_q[$];
    exp_instr_t  exp_instr_q[$];

    assign imem_rvalid = mem_rvalid | man_rvalid;
    assign imem_rdata  = man_rvalid ? man_rdata : mem_rdata;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .incr           (incr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc             (pc),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00a0_0113;
            32'h0000_0008: return 32'h0020_81b3;
            32'h0000_000C: return 32'h4020_8233;
            32'h0000_0100: return 32'h0010_0293;
            32'h0000_0104: return 32'hfff0_0313;
            default:       return 32'h0000_0013;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushReq(input logic [31:0] addr);
        exp_req_q.push_back(addr);
    endtask

    task automatic pushInstr(input logic [31:0] ipc, input logic [31:0] word);
        exp_instr_t e;
        e.pc   = ipc;
        e.word = word;
        exp_instr_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [31:0] rpc, input logic rvalid_now);
        redirect_valid = rvalid_now;
        redirect_pc    = rpc;
    endtask

    task automatic waitHold(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 40);
        if (!instr_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL hold_timeout: instr_valid got 0, expected 1 within 40 cycles");
        end
    endtask

    task automatic waitReq();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imem_req && n < 40);
        if (!imem_req) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_timeout: imem_req got 0, expected 1 within 40 cycles");
        end
    endtask

    // Memory model: answers each request one cycle later while enabled.
    initial begin
        logic [31:0] a;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (imem_req && !reset && mem_auto) begin
                a = imem_addr;
                @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(a);
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
            end
        end
    end

    // Monitor: compares every request address and each newly presented instruction.
    initial begin
        logic       prev_valid;
        logic [31:0] ea;
        exp_instr_t ei;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && imem_req) begin
                if (exp_req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL req_unexpected: got addr 0x%08h, expected no request", imem_addr);
                end else begin
                    ea = exp_req_q.pop_front();
                    checkOutput("req_addr", imem_addr, ea);
                end
            end
            if (!reset && instr_valid && !prev_valid) begin
                if (exp_instr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL instr_unexpected: got 0x%08h at pc 0x%08h, expected none", instr, pc);
                end else begin
                    ei = exp_instr_q.pop_front();
                    checkOutput("instr_word", instr, ei.word);
                    checkOutput("instr_pc", pc, ei.pc);
                    checkOutput("instr_fields", {funct7, rs2, rs1, funct3, rd, opcode}, ei.word);
                end
            end
            prev_valid = instr_valid;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset      = 1'b1;
        stall      = 1'b0;
        incr       = 1'b1;
        mem_auto   = 1'b1;
        man_rvalid = 1'b0;
        man_rdata  = '0;
        applyStimulus(32'h0, 1'b0);

        repeat (2) @(negedge clk);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr", instr, 32'h0000_0013);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_misalign", 32'(fetch_misalign), 32'd0);

        // Basic 3-cycle fetch from reset
        pushReq(32'h0);
        pushInstr(32'h0, 32'h0050_0093);
        pushReq(32'h4);
        pushInstr(32'h4, 32'h00a0_0113);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t1_req_c0", 32'(imem_req), 32'd1);
        waitHold(n);
        checkOutput("t1_latency", 32'(n), 32'd2);
        checkOutput("t1_opcode", 32'(opcode), 32'h13);
        checkOutput("t1_funct3", 32'(funct3), 32'd0);
        checkOutput("t1_rd", 32'(rd), 32'd1);
        checkOutput("t1_rs1", 32'(rs1), 32'd0);
        @(negedge clk);
        checkOutput("t1_req_c3", 32'(imem_req), 32'd1);

        // Stall holds the instruction register
        waitHold(n);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t2_valid", 32'(instr_valid), 32'd1);
            checkOutput("t2_instr", instr, 32'h00a0_0113);
            checkOutput("t2_pc", pc, 32'h4);
            checkOutput("t2_req", 32'(imem_req), 32'd0);
        end
        pushReq(32'h8);
        pushInstr(32'h8, 32'h0020_81b3);
        pushReq(32'h8);
        pushInstr(32'h8, 32'h0020_81b3);
        pushReq(32'hC);
        pushInstr(32'hC, 32'h4020_8233);
        pushReq(32'h10);
        stall = 1'b0;

        // incr=0 refetches the same pc
        waitHold(n);
        incr = 1'b0;
        @(negedge clk);
        incr = 1'b1;
        waitHold(n);
        checkOutput("t3_pc", pc, 32'h8);
        waitHold(n);

        // Redirect while waiting; the late response is stale
        mem_auto = 1'b0;
        waitReq();
        @(posedge clk); #1;
        applyStimulus(32'h100, 1'b1);
        @(posedge clk); #1;
        applyStimulus(32'h0, 1'b0);
        man_rvalid = 1'b1;
        man_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("t4_valid_w2", 32'(instr_valid), 32'd0);
        checkOutput("t4_pc", pc, 32'h100);
        checkOutput("t4_req_w2", 32'(imem_req), 32'd0);
        pushReq(32'h100);
        pushInstr(32'h100, 32'h0010_0293);
        @(posedge clk); #1;
        man_rvalid = 1'b0;
        mem_auto   = 1'b1;
        @(negedge clk);
        checkOutput("t4_valid_f", 32'(instr_valid), 32'd0);
        checkOutput("t4_req_f", 32'(imem_req), 32'd1);
        checkOutput("t4_misalign", 32'(fetch_misalign), 32'd0);

        // Misaligned redirect from HOLD ignores stall
        waitHold(n);
        stall = 1'b1;
        applyStimulus(32'h103, 1'b1);
        pushReq(32'h100);
        pushInstr(32'h100, 32'h0010_0293);
        pushReq(32'h104);
        @(posedge clk); #1;
        applyStimulus(32'h0, 1'b0);
        stall = 1'b0;
        @(negedge clk);
        checkOutput("t5_misalign_on", 32'(fetch_misalign), 32'd1);
        checkOutput("t5_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        checkOutput("t5_misalign_off", 32'(fetch_misalign), 32'd0);

        // Reset during WAIT; a response right after reset is ignored
        waitHold(n);
        mem_auto = 1'b0;
        waitReq();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_req_in_reset", 32'(imem_req), 32'd0);
        pushReq(32'h0);
        pushInstr(32'h0, 32'h0050_0093);
        @(posedge clk); #1;
        reset      = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("t6_addr", imem_addr, 32'h0);
        checkOutput("t6_valid_f", 32'(instr_valid), 32'd0);
        @(posedge clk); #1;
        man_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("t6_valid_w", 32'(instr_valid), 32'd0);
        checkOutput("t6_instr_kept", instr, 32'h0000_0013);
        @(posedge clk); #1;
        man_rvalid = 1'b1;
        man_rdata  = 32'h0050_0093;
        @(posedge clk); #1;
        man_rvalid = 1'b0;
        mem_auto   = 1'b1;

        // PC wraps modulo 2^32
        @(negedge clk);
        checkOutput("t7_hold_valid", 32'(instr_valid), 32'd1);
        applyStimulus(32'hFFFF_FFFC, 1'b1);
        pushReq(32'hFFFF_FFFC);
        pushInstr(32'hFFFF_FFFC, 32'h0000_0013);
        pushReq(32'h0);
        pushInstr(32'h0, 32'h0050_0093);
        @(posedge clk); #1;
        applyStimulus(32'h0, 1'b0);
        waitHold(n);
        waitHold(n);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("sb_req_empty", 32'(exp_req_q.size()), 32'd0);
        checkOutput("sb_instr_empty", 32'(exp_instr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Holds the PC and issues one request at a time to instruction memory. It captures the returned word in an instruction register and presents the opcode/funct3/funct7/register fields to the decoder.
- Consumes the decoder's `incr` output and a stall to decide when and how to advance, and accepts a branch/jump redirect from execute.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  request strobe; memory accepts it in the same cycle.
- imem_addr  output  XLEN  word-aligned fetch address.
- imem_rvalid  input  1  response valid; arrives 1 or more cycles after the request.
- imem_rdata  input  32  instruction word.
- stall  input  1  decoder/control not ready to consume the held instruction (e.g. second cycle of a load).
- incr  input  1  from decoder; 1 = advance PC by 4 on consume, 0 = refetch same PC.
- redirect_valid  input  1  branch/jump taken.
- redirect_pc  input  XLEN  redirect target.
- instr_valid  output  1  instruction register holds a live instruction.
- instr  output  32  instruction register.
- pc  output  XLEN  PC of `instr`.
- opcode  output  7  instr[6:0].
- funct3  output  3  instr[14:12].
- funct7  output  7  instr[31:25].
- rd  output  5  instr[11:7].
- rs1  output  5  instr[19:15].
- rs2  output  5  instr[24:20].
- fetch_misalign  output  1  one-cycle pulse when redirect_pc[1:0] != 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - State is FETCH.
  - pc = RESET_PC; kill = 0.
  - instr_valid = 0, instr = 32'h0000_0013 (NOP), fetch_misalign = 0.
  - imem_req = 0 while reset is asserted.
- Field outputs are pure slices of `instr`.
- States:
  - FETCH: imem_req = 1, imem_addr = pc. Next state is WAIT unconditionally.
  - WAIT: imem_req = 0. Waits for imem_rvalid.
    - On rvalid with kill = 0: instr <= imem_rdata, instr_valid <= 1, go to HOLD.
    - On rvalid with kill = 1: discard the data, clear kill, go to FETCH.
  - HOLD: instr_valid = 1; instr and pc are stable.
    - If stall = 1: remain in HOLD, no request.
    - If stall = 0 (consume): pc <= incr ? pc+4 : pc; instr_valid <= 0; go to FETCH.
- Latency: with 1-cycle memory there are 3 cycles per instruction.
  - Cycle 0 FETCH, cycle 1 WAIT (rvalid), cycle 2 HOLD/consume, cycle 3 next FETCH.
- Redirect has priority over everything except reset, in any state:
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}; instr_valid <= 0.
  - In FETCH: the issued request is stale. Go to WAIT with kill <= 1.
  - In WAIT without rvalid: set kill <= 1 and stay in WAIT.
  - In WAIT with rvalid in the same cycle: discard the data, go to FETCH.
  - In HOLD: go to FETCH; stall and incr are ignored.
- fetch_misalign pulses one cycle after a redirect with nonzero low bits.
- PC arithmetic is modulo 2^XLEN: 0xFFFF_FFFC + 4 wraps to 0.
- At most one request is outstanding. imem_rvalid in FETCH or HOLD is ignored.
- Reset mid-operation: all state returns to reset values. A response that arrives after reset for a pre-reset request lands in FETCH and is therefore ignored.

Decomposition:
- Shared package rv_pkg (alongside the existing opcode defines) holds:
  - fetch_state_t enum {FETCH, WAIT, HOLD};
  - the NOP constant 32'h0000_0013;
  - the XLEN default.
- No sub-module is needed. A single always_ff covers state/pc/instr/kill, and a single always_comb covers next-state and imem_req.

Test Plan:
- Reset release, 1-cycle memory returning 0x00500093 for address 0:
  - imem_req=1, addr=0x0 in cycle 0;
  - instr_valid=1 in cycle 2 with opcode=0x13, funct3=0, rd=1, rs1=0;
  - next request addr=0x4 in cycle 3.
- stall=1 for 3 cycles in HOLD: instr, pc and instr_valid are stable and imem_req stays 0. On release, the next request is to pc+4.
- incr=0 at consume with pc=0x8: the next request addr is 0x8 and the same word is re-presented.
- redirect_valid with redirect_pc=0x100 during WAIT, rvalid one cycle later with 0xDEADBEEF:
  - the data is discarded and instr_valid stays 0;
  - the next request addr is 0x100.
- redirect_pc=0x103 in HOLD: fetch_misalign pulses for 1 cycle, and the next request addr is 0x100.
- reset asserted in WAIT, then rvalid arriving in the first cycle after reset: the response is ignored, imem_addr=RESET_PC, instr_valid=0.
